// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned AW_DEFAULT = 8;
  localparam int unsigned ILEN       = 32;

  // add x0,x0,x0
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0033;

  typedef struct packed {
    logic [ILEN-1:0]       instr;
    logic [AW_DEFAULT-1:0] pc;
  } entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with push, pop, flush and level.
// Flush has priority over push and pop. The caller never pushes when full
// unless it pops in the same cycle, and never pops when empty.
module fetch_fifo #(
  parameter int unsigned Width = 40,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [Width-1:0]           wdata_i,
  output logic [Width-1:0]           rdata_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(Depth+1)-1:0] level_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [Width-1:0] mem_q [Depth];

  // Pointer and count next-state; flush clears everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push_i, pop_i})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; contents are only visible while count is nonzero.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Head read and status flags.
  always_comb begin
    rdata_o = mem_q[rd_ptr_q];
    empty_o = (count_q == '0);
    full_o  = (count_q == CntW'(Depth));
    level_o = count_q;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: fetch PC, redirect handling and the
// instruction/PC queue feeding decode.
// Optional feature: define FETCH_BYPASS_EN to forward the memory word
// straight to decode when the queue is empty (zero-cycle fetch latency).
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned    DEPTH    = 4,
  parameter int unsigned    AW       = AW_DEFAULT,
  parameter logic [AW-1:0]  RESET_PC = AW'(4)
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_en,
  output logic [AW-1:0]              imem_addr,
  input  logic [ILEN-1:0]            imem_data,
  input  logic                       redirect,
  input  logic [AW-1:0]              redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ILEN-1:0]            out_instr,
  output logic [AW-1:0]              out_pc,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  logic [AW-1:0]      fpc_q, fpc_d;
  logic [ILEN+AW-1:0] q_rdata;
  logic               q_push, q_pop, q_empty, q_full;
  logic               bypass;

  fetch_fifo #(
    .Width (ILEN + AW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (q_push),
    .pop_i   (q_pop),
    .flush_i (redirect),
    .wdata_i ({imem_data, fpc_q}),
    .rdata_o (q_rdata),
    .empty_o (q_empty),
    .full_o  (q_full),
    .level_o (level)
  );

  // Fetch request, queue handshake and decode-facing outputs.
  always_comb begin
    // Queue-side pop only; keeps imem_en free of the bypass valid path.
    q_pop     = ~q_empty & out_ready;
    imem_en   = rst & ~redirect & (~q_full | q_pop);
    imem_addr = fpc_q;
`ifdef FETCH_BYPASS_EN
    bypass    = q_empty & ~redirect;
`else
    bypass    = 1'b0;
`endif
    // A bypassed word that decode accepts this cycle never enters the queue.
    q_push    = imem_en & ~(bypass & out_ready);
    if (bypass) begin
      out_valid = imem_en;
      out_instr = imem_en ? imem_data : '0;
      out_pc    = imem_en ? fpc_q : '0;
    end else begin
      out_valid = ~q_empty;
      out_instr = q_empty ? '0 : q_rdata[ILEN+AW-1:AW];
      out_pc    = q_empty ? '0 : q_rdata[AW-1:0];
    end
  end

  // Fetch PC next-state: redirect wins, otherwise advance on each fetch.
  always_comb begin
    fpc_d = fpc_q;
    if (redirect) begin
      fpc_d = {redirect_pc[AW-1:2], 2'b00};
    end else if (imem_en) begin
      fpc_d = fpc_q + AW'(4);
    end
  end

  // Fetch PC register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) fpc_q <= RESET_PC;
    else      fpc_q <= fpc_d;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction-fetch front end for the RV32IM core. It drives the instruction side of the unified single-port memory with a program counter, captures each returned instruction word together with its PC, and buffers the pairs in a small FIFO. Decode drains the FIFO through a valid/ready handshake. Control transfers resolved downstream (branch, jal, jalr) arrive as a redirect, which flushes the queue and reloads the PC.

## Interface
Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2
- AW, 8, byte-address width of the instruction port
- RESET_PC, 8'd4, fetch address after reset; word 0 holds a padding nop

Ports:
- clk  in  1  system clock; all state updates on the posedge
- rst  in  1  synchronous, active-low reset
- imem_en  out  1  fetch request this cycle
- imem_addr  out  AW  byte address of the instruction word being fetched
- imem_data  in  32  instruction word; valid combinationally, in the same cycle, for imem_addr
- redirect  in  1  flush the queue and restart fetch this cycle
- redirect_pc  in  AW  new fetch address, sampled when redirect=1
- out_valid  out  1  head entry is available to decode
- out_ready  in  1  decode accepts the head entry
- out_instr  out  32  head instruction; 0 when out_valid=0
- out_pc  out  AW  head PC; 0 when out_valid=0
- level  out  $clog2(DEPTH+1)  current entry count

## Operation
State:
- fpc: fetch PC
- wr_ptr, rd_ptr: queue pointers
- count: entry count
- DEPTH x {instr, pc} storage

Fetch:
- imem_en = rst & ~redirect & (count<DEPTH | pop).
- pop = out_valid & out_ready.
- imem_addr = fpc at all times.

Push:
- When imem_en=1, {imem_data, fpc} is written at wr_ptr on the posedge.
- wr_ptr increments and fpc advances by 4, modulo 2^AW (0xFC wraps to 0x00).

Pop:
- When pop=1, rd_ptr increments.
- count is updated by +push -pop; a simultaneous push and pop leaves count unchanged, including at full.

Redirect (takes priority over push and pop):
- count, wr_ptr and rd_ptr are cleared; no push occurs.
- fpc is loaded with {redirect_pc[AW-1:2], 2'b00}; misaligned low bits are discarded.
- A pop that handshakes in the same cycle is considered consumed, and its entry is discarded by the flush.

Reset (rst=0 at a posedge), including in the middle of operation:
- fpc = RESET_PC; count = 0; both pointers = 0.
- Outputs: out_valid=0, out_instr=0, out_pc=0, level=0.
- imem_en=0 while rst=0.
- Storage contents are don't-care.

Output mapping:
- out_valid = (count != 0).
- Head fields are masked to 0 when the queue is empty.

## Timing
- Fetch-to-decode latency is 1 cycle: a word fetched at cycle n is at the head at cycle n+1 if the queue was empty.
- With out_ready held at 1, throughput is one instruction per cycle with no bubbles.
- First cycle after rst rises: imem_addr=RESET_PC, imem_en=1. out_valid rises one cycle later.
- Redirect at cycle n: out_valid=0 in cycle n+1, with imem_addr=redirect target in cycle n+1. The target instruction is at the head in cycle n+2.
- Queue full with out_ready=0: imem_en=0, fpc holds, no word is dropped or duplicated.
- out_valid, out_instr and out_pc are stable while out_valid=1 and out_ready=0.

## Configuration
- FETCH_BYPASS_EN defined:
  - When count=0 and redirect=0, out_valid=imem_en, out_instr=imem_data and out_pc=fpc, all combinationally.
  - If out_ready=1 in that cycle, the word is not written into the queue.
  - Minimum latency becomes 0 cycles. Redirect still costs one empty cycle.
- FETCH_BYPASS_EN undefined:
  - All outputs come from queue storage; minimum latency is 1 cycle as above.

## Structure
- Package fetch_pkg holds:
  - AW default
  - ILEN=32
  - NOP_INSTR=32'h00000033 (add x0,x0,x0)
  - entry typedef {instr, pc}
- Sub-module fetch_fifo: generic synchronous FIFO with push, pop, flush and level. fetch_queue contains the PC, the redirect logic and the bypass path.

## Test plan
Bench model: combinational instruction memory where word 4 = 0x00002083 (lw x1,0(x0)) and word 8 = 0x00402103 (lw x2,4(x0)).

- Release rst with out_ready=1 -> cycle 1: out_valid=1, out_pc=4, out_instr=0x00002083; cycle 2: out_pc=8, out_instr=0x00402103; continuous thereafter.
- Hold out_ready=0 for 10 cycles -> level saturates at 4, imem_en=0 after the 4th push, out_pc held at 4. Then set out_ready=1 -> PCs 4, 8, 12, 16, 20, 24… in consecutive cycles, with no gap or duplicate.
- At level=3, assert redirect with redirect_pc=0x5C and out_ready=1 -> next cycle: level=0, out_valid=0, imem_addr=0x5C; the cycle after: out_pc=0x5C.
- redirect_pc=0x5E -> fetch address 0x5C. Redirect to 0xFC -> fetched PCs 0xFC, then 0x00.
- Drive rst=0 for one cycle at level=2 mid-stream -> next cycle: level=0, out_valid=0, out_instr=0. After release, imem_addr=4.
- Under FETCH_BYPASS_EN, with the queue empty and out_ready=1 -> out_pc equals imem_addr in the same cycle, and level stays 0.
